// File: rtl/addsub_unit.sv
// Multi-cycle add/subtract unit: CHUNK bits per clock, LSB chunk first.
// Modes ADD/SUB/ADC/ACC, registered CARRY/OVF/ZERO/NEG, START/BUSY/DONE.
//
// Ports:
//   CLK      rising-edge clock
//   RST_N    asynchronous active-low reset
//   START    request, sampled in IDLE or DONE
//   MODE     00 ADD, 01 SUB, 10 ADC, 11 ACC (sampled with START)
//   A, B     operands (sampled with START; B unused in ACC)
//   ACC_CLR  synchronous accumulator clear
//   BUSY     high while an operation is running
//   DONE     one-cycle completion pulse
//   SUM      registered result, held until the next completion
//   CARRY    carry-out (SUB: 1 = no borrow)
//   OVF      signed overflow
//   ZERO     SUM == 0
//   NEG      SUM sign bit
module addsub_unit #(
   parameter int WIDTH = 8,
   parameter int CHUNK = 4
) (
   input  logic             CLK,
   input  logic             RST_N,
   input  logic             START,
   input  logic [1:0]       MODE,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             ACC_CLR,
   output logic             BUSY,
   output logic             DONE,
   output logic [WIDTH-1:0] SUM,
   output logic             CARRY,
   output logic             OVF,
   output logic             ZERO,
   output logic             NEG
);

   localparam int NCHUNK = WIDTH / CHUNK;
   localparam int IW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
   localparam logic [IW-1:0] LAST = IW'(NCHUNK - 1);

   localparam logic [1:0] M_ADD = 2'b00;
   localparam logic [1:0] M_SUB = 2'b01;
   localparam logic [1:0] M_ADC = 2'b10;
   localparam logic [1:0] M_ACC = 2'b11;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t r_state;
   state_t w_next;

   logic             w_load;
   logic             w_last;

   // Latched operation
   logic [WIDTH-1:0] r_x;
   logic [WIDTH-1:0] r_y;
   logic             r_c;
   logic [IW-1:0]    r_idx;
   logic             r_is_acc;
   logic [WIDTH-1:0] r_work;

   // Architectural state
   logic [WIDTH-1:0] r_acc;
   logic [WIDTH-1:0] r_sum;
   logic             r_carry;
   logic             r_ovf;
   logic             r_zero;
   logic             r_neg;

   // Operand selection at START
   logic [WIDTH-1:0] w_x_in;
   logic [WIDTH-1:0] w_y_in;
   logic             w_cin;

   // Chunk adder
   int               w_base;
   logic [CHUNK-1:0] w_xc;
   logic [CHUNK-1:0] w_yc;
   logic [CHUNK:0]   w_csum;
   logic [WIDTH-1:0] w_res;
   logic             w_cmsb;
   logic             w_ovf;

   // ---------------------------------------------------------------
   // FSM
   // ---------------------------------------------------------------
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      w_load = 1'b0;
      w_last = 1'b0;
      unique case (r_state)
         S_IDLE: begin
            if (START) begin
               w_load = 1'b1;
               w_next = S_RUN;
            end
         end
         S_RUN: begin
            if (r_idx == LAST) begin
               w_last = 1'b1;
               w_next = S_DONE;
            end
         end
         S_DONE: begin
            if (START) begin
               w_load = 1'b1;
               w_next = S_RUN;
            end else begin
               w_next = S_IDLE;
            end
         end
         default: begin
            w_next = S_IDLE;
         end
      endcase
   end

   // ---------------------------------------------------------------
   // Operand decode
   // ---------------------------------------------------------------
   always_comb begin
      w_x_in = A;
      w_y_in = B;
      w_cin  = 1'b0;
      unique case (1'b1)
         (MODE == M_ADD): begin
            w_x_in = A;
            w_y_in = B;
            w_cin  = 1'b0;
         end
         (MODE == M_SUB): begin
            w_x_in = A;
            w_y_in = ~B;
            w_cin  = 1'b1;
         end
         // ADC chains off the carry left by the previous operation
         (MODE == M_ADC): begin
            w_x_in = A;
            w_y_in = B;
            w_cin  = r_carry;
         end
         (MODE == M_ACC): begin
            w_x_in = r_acc;
            w_y_in = A;
            w_cin  = 1'b0;
         end
         default: begin
            w_x_in = A;
            w_y_in = B;
            w_cin  = 1'b0;
         end
      endcase
   end

   // ---------------------------------------------------------------
   // Chunk datapath
   // ---------------------------------------------------------------
   always_comb begin
      w_base = int'(r_idx) * CHUNK;
      w_xc   = r_x[w_base +: CHUNK];
      w_yc   = r_y[w_base +: CHUNK];
      w_csum = {1'b0, w_xc} + {1'b0, w_yc} + (CHUNK+1)'(r_c);
      w_res  = r_work;
      w_res[w_base +: CHUNK] = w_csum[CHUNK-1:0];
   end

   // Carry into the MSB recovered from the MSB sum bit; only meaningful
   // on the last chunk, which is the only time it is registered.
   assign w_cmsb = r_x[WIDTH-1] ^ r_y[WIDTH-1] ^ w_res[WIDTH-1];
   assign w_ovf  = w_cmsb ^ w_csum[CHUNK];

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         r_x      <= '0;
         r_y      <= '0;
         r_c      <= 1'b0;
         r_idx    <= '0;
         r_is_acc <= 1'b0;
         r_work   <= '0;
      end else if (w_load) begin
         r_x      <= w_x_in;
         r_y      <= w_y_in;
         r_c      <= w_cin;
         r_idx    <= '0;
         r_is_acc <= (MODE == M_ACC);
         r_work   <= '0;
      end else if (r_state == S_RUN) begin
         r_work   <= w_res;
         r_c      <= w_csum[CHUNK];
         r_idx    <= r_idx + 1'b1;
      end
   end

   // ---------------------------------------------------------------
   // Result and flags, updated together at completion
   // ---------------------------------------------------------------
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         r_sum   <= '0;
         r_carry <= 1'b0;
         r_ovf   <= 1'b0;
         r_zero  <= 1'b0;
         r_neg   <= 1'b0;
      end else if (w_last) begin
         r_sum   <= w_res;
         r_carry <= w_csum[CHUNK];
         r_ovf   <= w_ovf;
         r_zero  <= (w_res == '0);
         r_neg   <= w_res[WIDTH-1];
      end
   end

   // Clear has priority over an ACC write-back on the same edge
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         r_acc <= '0;
      end else if (ACC_CLR) begin
         r_acc <= '0;
      end else if (w_last && r_is_acc) begin
         r_acc <= w_res;
      end
   end

   assign BUSY  = (r_state == S_RUN);
   assign DONE  = (r_state == S_DONE);
   assign SUM   = r_sum;
   assign CARRY = r_carry;
   assign OVF   = r_ovf;
   assign ZERO  = r_zero;
   assign NEG   = r_neg;

endmodule

// File: tb/tb_addsub_unit.sv
// Self-checking bench for addsub_unit (8/4 and 32/8 instances).
// Scoreboard queue of expected results, compared at DONE.
module tb_addsub_unit;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_n;

   logic       s_start;
   logic [1:0] s_mode;
   logic [7:0] s_a;
   logic [7:0] s_b;
   logic       s_clr;
   logic       s_busy;
   logic       s_done;
   logic [7:0] s_sum;
   logic       s_carry;
   logic       s_ovf;
   logic       s_zero;
   logic       s_neg;

   logic        t_start;
   logic [1:0]  t_mode;
   logic [31:0] t_a;
   logic [31:0] t_b;
   logic        t_clr;
   logic        t_busy;
   logic        t_done;
   logic [31:0] t_sum;
   logic        t_carry;
   logic        t_ovf;
   logic        t_zero;
   logic        t_neg;

   addsub_unit #(.WIDTH(8), .CHUNK(4)) u_dut8 (
      .CLK(clk), .RST_N(rst_n), .START(s_start), .MODE(s_mode),
      .A(s_a), .B(s_b), .ACC_CLR(s_clr), .BUSY(s_busy), .DONE(s_done),
      .SUM(s_sum), .CARRY(s_carry), .OVF(s_ovf), .ZERO(s_zero),
      .NEG(s_neg)
   );

   addsub_unit #(.WIDTH(32), .CHUNK(8)) u_dut32 (
      .CLK(clk), .RST_N(rst_n), .START(t_start), .MODE(t_mode),
      .A(t_a), .B(t_b), .ACC_CLR(t_clr), .BUSY(t_busy), .DONE(t_done),
      .SUM(t_sum), .CARRY(t_carry), .OVF(t_ovf), .ZERO(t_zero),
      .NEG(t_neg)
   );

   typedef struct packed {
      logic [7:0] sum;
      logic       c;
      logic       o;
      logic       z;
      logic       n;
   } exp_t;

   exp_t        q[$];
   logic [35:0] q32[$];
   logic        m_carry;
   logic [7:0]  m_acc;

   int n_assert = 0;
   int n_fail   = 0;

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference model: plain wide add, overflow from operand/result signs
   task automatic push(input logic [1:0] m, input logic [7:0] a,
                       input logic [7:0] b);
      logic [7:0] x;
      logic [7:0] y;
      logic       ci;
      logic [8:0] r;
      exp_t       e;
      x  = a;
      y  = b;
      ci = 1'b0;
      case (m)
         2'd0: begin x = a;     y = b;  ci = 1'b0;    end
         2'd1: begin x = a;     y = ~b; ci = 1'b1;    end
         2'd2: begin x = a;     y = b;  ci = m_carry; end
         default: begin x = m_acc; y = a; ci = 1'b0; end
      endcase
      r     = {1'b0, x} + {1'b0, y} + {8'd0, ci};
      e.sum = r[7:0];
      e.c   = r[8];
      e.o   = (x[7] == y[7]) && (r[7] != x[7]);
      e.z   = (r[7:0] == 8'd0);
      e.n   = r[7];
      m_carry = e.c;
      if (m == 2'd3) m_acc = r[7:0];
      q.push_back(e);
   endtask

   task automatic pop_cmp(input string tag);
      exp_t e;
      chk({tag, "_sb"}, 64'(q.size() > 0), 64'd1);
      if (q.size() > 0) begin
         e = q.pop_front();
         chk(tag, 64'({s_sum, s_carry, s_ovf, s_zero, s_neg}), 64'(e));
      end
   endtask

   // One 8-bit operation; optional ACC_CLR on the completion edge
   task automatic op(input string tag, input logic [1:0] m,
                     input logic [7:0] a, input logic [7:0] b,
                     input bit clr_done);
      int cnt;
      int busy;
      s_mode  = m;
      s_a     = a;
      s_b     = b;
      s_start = 1'b1;
      push(m, a, b);
      @(posedge clk); #1;
      s_start = 1'b0;
      s_mode  = ~m;
      s_a     = ~a;
      s_b     = ~b;
      cnt  = 0;
      busy = int'(s_busy);
      while (!s_done && cnt < 20) begin
         if (clr_done && cnt == 1) s_clr = 1'b1;
         @(posedge clk); #1;
         cnt++;
         if (!s_done) busy += int'(s_busy);
      end
      s_clr = 1'b0;
      if (clr_done) m_acc = 8'd0;
      chk({tag, "_lat"}, 64'(cnt), 64'd2);
      chk({tag, "_busy"}, 64'(busy), 64'd2);
      pop_cmp(tag);
   endtask

   task automatic op32(input string tag, input logic [31:0] a,
                       input logic [31:0] b, input logic [35:0] e);
      int cnt;
      logic [35:0] x;
      t_mode  = 2'd0;
      t_a     = a;
      t_b     = b;
      t_start = 1'b1;
      q32.push_back(e);
      @(posedge clk); #1;
      t_start = 1'b0;
      t_a     = ~a;
      cnt = 0;
      while (!t_done && cnt < 20) begin
         @(posedge clk); #1;
         cnt++;
      end
      chk({tag, "_lat"}, 64'(cnt), 64'd4);
      x = q32.pop_front();
      chk(tag, 64'({t_sum, t_carry, t_ovf, t_zero, t_neg}), 64'(x));
   endtask

   initial begin
      int bad;
      exp_t z;
      logic [7:0] ta[3];
      logic [7:0] tb[3];
      rst_n   = 1'b0;
      s_start = 1'b0; s_mode = 2'd0; s_a = 8'd0; s_b = 8'd0; s_clr = 1'b0;
      t_start = 1'b0; t_mode = 2'd0; t_a = '0;   t_b = '0;   t_clr = 1'b0;
      m_carry = 1'b0;
      m_acc   = 8'd0;
      z       = '0;

      #2;
      chk("reset8",
          64'({s_busy, s_done, s_sum, s_carry, s_ovf, s_zero, s_neg}), 64'd0);
      chk("reset32",
          64'({t_busy, t_done, t_sum, t_carry, t_ovf, t_zero, t_neg}), 64'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;

      op("add_7f_01", 2'd0, 8'h7F, 8'h01, 1'b0);
      op("sub_10_10", 2'd1, 8'h10, 8'h10, 1'b0);
      op("sub_00_01", 2'd1, 8'h00, 8'h01, 1'b0);
      op("sub_80_01", 2'd1, 8'h80, 8'h01, 1'b0);
      op("add_ff_01", 2'd0, 8'hFF, 8'h01, 1'b0);
      op("adc_1", 2'd2, 8'h00, 8'h00, 1'b0);
      op("adc_2", 2'd2, 8'h00, 8'h00, 1'b0);
      op("adc_3c", 2'd2, 8'hA0, 8'h70, 1'b0);

      s_clr = 1'b1;
      @(posedge clk); #1;
      s_clr = 1'b0;
      m_acc = 8'd0;
      op("acc_1", 2'd3, 8'h05, 8'h00, 1'b0);
      op("acc_2", 2'd3, 8'h05, 8'h00, 1'b0);
      op("acc_3", 2'd3, 8'h05, 8'h00, 1'b0);
      op("acc_clr_done", 2'd3, 8'h01, 8'h00, 1'b1);
      op("acc_after_clr", 2'd3, 8'h03, 8'h00, 1'b0);

      // Back-to-back with START held and operands toggled during RUN
      ta[0] = 8'h12; tb[0] = 8'h34;
      ta[1] = 8'h90; tb[1] = 8'h90;
      ta[2] = 8'h01; tb[2] = 8'hFE;
      s_mode  = 2'd0;
      s_a     = ta[0];
      s_b     = tb[0];
      s_start = 1'b1;
      push(2'd0, ta[0], tb[0]);
      for (int j = 0; j < 3; j++) begin
         @(posedge clk); #1;
         chk("b2b_run0", 64'({s_busy, s_done}), 64'd2);
         s_a = 8'hC3;
         s_b = 8'h5A;
         @(posedge clk); #1;
         chk("b2b_run1", 64'({s_busy, s_done}), 64'd2);
         s_a = 8'h77;
         s_b = 8'h88;
         @(posedge clk); #1;
         chk("b2b_done", 64'({s_busy, s_done}), 64'd1);
         pop_cmp("b2b_result");
         if (j < 2) begin
            s_a = ta[j+1];
            s_b = tb[j+1];
            push(2'd0, ta[j+1], tb[j+1]);
         end else begin
            s_start = 1'b0;
         end
      end
      @(posedge clk); #1;
      chk("b2b_idle", 64'({s_busy, s_done}), 64'd0);

      op32("w32_ffff_1", 32'hFFFFFFFF, 32'd1, {32'd0, 4'b1010});
      op32("w32_7fff_1", 32'h7FFFFFFF, 32'd1, {32'h80000000, 4'b0101});

      // Asynchronous reset in the middle of RUN
      op("pre_reset", 2'd0, 8'h40, 8'h13, 1'b0);
      s_a     = 8'h12;
      s_b     = 8'h34;
      s_start = 1'b1;
      @(posedge clk); #1;
      s_start = 1'b0;
      chk("mid_busy", 64'(s_busy), 64'd1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_reset",
          64'({s_busy, s_done, s_sum, s_carry, s_ovf, s_zero, s_neg}),
          64'(z));
      #3;
      rst_n = 1'b1;
      m_carry = 1'b0;
      m_acc   = 8'd0;
      bad = 0;
      for (int i = 0; i < 6; i++) begin
         @(posedge clk); #1;
         if (s_done || s_busy) bad++;
      end
      chk("post_reset_idle", 64'(bad), 64'd0);
      op("post_reset_add", 2'd0, 8'h22, 8'h11, 1'b0);
      op("post_reset_adc", 2'd2, 8'h01, 8'h01, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/addsub_unit.md
Name: addsub_unit

Overview:
Parametrised multi-cycle add/subtract unit for the mini-processor datapath. It replaces fixed-width combinational adders and processes CHUNK bits per clock over WIDTH/CHUNK cycles. It supports four modes: ADD, SUB, ADC (add with stored carry) and ACC (accumulate). It produces CARRY/OVF/ZERO/NEG status flags for the control unit, and a START/BUSY/DONE handshake is used to sequence operations.

Parameters:
WIDTH, 8, operand/result width in bits; must be a multiple of CHUNK.
CHUNK, 4, bits added per clock cycle. NCHUNK = WIDTH/CHUNK, at least 1.

Ports:
CLK  input  1  rising-edge clock.
RST_N  input  1  asynchronous active-low reset.
START  input  1  request; sampled only in IDLE or DONE state.
MODE  input  2  00 ADD, 01 SUB, 10 ADC, 11 ACC; sampled with START.
A  input  WIDTH  operand A; sampled with START.
B  input  WIDTH  operand B; sampled with START; unused in ACC.
ACC_CLR  input  1  synchronous clear of the internal accumulator.
BUSY  output  1  high while in RUN.
DONE  output  1  one-cycle completion pulse.
SUM  output  WIDTH  registered result; held until the next completion.
CARRY  output  1  carry-out (SUB: 1 = no borrow, i.e. A >= B unsigned).
OVF  output  1  signed two's-complement overflow.
ZERO  output  1  SUM == 0.
NEG  output  1  SUM[WIDTH-1].

Behaviour:
- Reset: RST_N low clears state immediately, regardless of clock. State = IDLE. BUSY, DONE, SUM, CARRY, OVF, ZERO, NEG = 0. Accumulator = 0. An in-flight operation is discarded.
- FSM states: IDLE, RUN, DONE.
  - IDLE, START=1: latch operands, go to RUN. Otherwise stay in IDLE.
  - RUN: add one chunk per cycle, least-significant chunk first. After chunk NCHUNK-1, go to DONE. START is ignored.
  - DONE: DONE=1 for exactly this cycle. START=1 latches a new operation and goes to RUN (back-to-back). Otherwise go to IDLE.
- Operand latch at START:
  - X = A for ADD, SUB, ADC; X = accumulator for ACC.
  - Y = B for ADD, ADC; Y = ~B for SUB; Y = A for ACC.
  - cin = 0 for ADD and ACC; cin = 1 for SUB; cin = current CARRY output for ADC.
  - MODE, A and B changes after START have no effect on the running operation.
- Chunk step i: {c, S[i*CHUNK +: CHUNK]} = X chunk + Y chunk + c. The carry register is initialised to cin.
- Latency: START sampled at edge k gives SUM, flags and DONE updated at edge k+NCHUNK. Back-to-back throughput is one operation per NCHUNK+1 cycles.
- Flag rules, all registered together with SUM at completion edge:
  - CARRY = final carry-out.
  - OVF = carry into bit WIDTH-1 XOR carry out of bit WIDTH-1.
  - ZERO and NEG are derived from the new SUM.
- ACC mode: the accumulator is also written with the result at the completion edge. SUM shows the new accumulator value.
- ACC_CLR:
  - Clears the accumulator at the next edge in any state.
  - If asserted on the same edge as an ACC completion, the clear wins: accumulator = 0. SUM and flags still show the computed result.
  - ACC_CLR does not affect SUM or the flags.
- Wrap-around: the result is modulo 2^WIDTH; overflow is reported only via CARRY and OVF.
- When NCHUNK=1, RUN lasts one cycle; latency is 1.

Test Plan:
- WIDTH=8, CHUNK=4. Reset, then ADD A=0x7F B=0x01 -> DONE pulses 2 cycles after START sampled; SUM=0x80, CARRY=0, OVF=1, NEG=1, ZERO=0. BUSY is high for exactly 2 cycles.
- SUB 0x10-0x10 -> SUM=0x00, ZERO=1, CARRY=1, OVF=0. Then SUB 0x00-0x01 -> SUM=0xFF, CARRY=0, NEG=1. Then SUB 0x80-0x01 -> SUM=0x7F, OVF=1.
- ADD 0xFF+0x01 -> SUM=0x00, CARRY=1, ZERO=1. Then ADC A=0x00 B=0x00 -> SUM=0x01, CARRY=0. Then ADC A=0x00 B=0x00 again -> SUM=0x00.
- Pulse ACC_CLR, then ACC A=0x05 three times -> SUM=0x05, 0x0A, 0x0F. Then ACC A=0x01 with ACC_CLR on the completion edge -> SUM=0x10; the next ACC A=0x03 -> SUM=0x03.
- START held high continuously with A/B toggled during RUN -> new starts are accepted only in DONE; DONE pulses every 3 cycles; each result matches the operands present at its accepting edge. Repeat with WIDTH=32, CHUNK=8: ADD 0xFFFFFFFF+1 -> SUM=0, CARRY=1, latency 4.
- Drive RST_N low mid-RUN, asynchronously between edges -> BUSY, DONE, SUM and flags go to 0 immediately. After release, the unit stays IDLE with no DONE until the next START.
